max7219_rx: RTL and testbench

Receive-side counterpart of the MAX7219 display driver: a MAX7219-compatible SPI responder that deserialises 16-bit frames from `sclk`/`mosi`/`sel`, holds the device register file and reconstructs the signed number shown on the 8-digit display. It sits on the FPGA fabric as a loopback or monitor target for driver verification, or as an emulated display feeding a readable value back to the host interface.

---
 rtl/max7219_rx.sv | 231 +++++++++++++++++++++++
 tb/tb_max7219_rx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_rx.sv
// MAX7219-compatible SPI responder: receives 16-bit frames, holds the register file,
// and turns the eight digit registers back into the signed number on the display.
module max7219_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        sel,
    output logic [23:0] value,
    output logic        valid,
    output logic        value_strobe,
    output logic        frame_strobe,
    output logic        frame_error,
    output logic [7:0]  decode_mode,
    output logic [3:0]  intensity,
    output logic [2:0]  scan_limit,
    output logic        shutdown,
    output logic        display_test
);

    // state | meaning
    // IDLE  | waiting for a digit or decode-mode write
    // LOAD  | clear accumulator, point at digit 5
    // MAC   | acc = acc*10 + digit, digit 5 down to 0
    // SIGN  | apply digit 6 sign, hand result to the output register
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_MAC, ST_SIGN} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, sel_sync_q;
    logic        sclk_prev_q, sel_prev_q;
    logic        frame_active_q, sel_rise_q;
    logic [4:0]  bit_cnt_q;
    // Only the low 12 bits of a frame carry information; the top nibble is don't-care.
    logic [11:0] shift_q;

    logic [6:0]  digit_q [8];
    logic [7:0]  decode_mode_q;
    logic [3:0]  intensity_q;
    logic [2:0]  scan_limit_q;
    logic        shutdown_q, display_test_q;
    logic        frame_strobe_q, frame_error_q;

    state_t      state_q;
    logic [2:0]  idx_q;
    logic [19:0] acc_q;
    logic        digits_ok_q;
    logic [23:0] result_q;
    logic        result_ok_q, pending_q;
    logic [23:0] value_q;
    logic        valid_q, value_strobe_q;

    logic sclk_s, mosi_s, sel_s, sel_fall, sel_rise, sclk_rise;
    logic frame_ok, decode_trig;
    logic [3:0] frame_addr;
    logic [7:0] frame_data;
    logic [2:0] digit_wr_idx, cur_idx;
    logic [6:0] cur_dec;
    logic [19:0] acc_d;
    logic [23:0] result_d;

    // {blank, minus, numeric, value[3:0]}; DP is never stored so it cannot matter here
    function automatic logic [6:0] decode_digit(input logic [6:0] seg, input logic code_b);
        logic [6:0] r;
        r = '0;
        if (code_b) begin
            if (seg[3:0] <= 4'd9)       r = {3'b001, seg[3:0]};
            else if (seg[3:0] == 4'hA)  r = 7'b010_0000;
            else if (seg[3:0] == 4'hF)  r = 7'b100_0000;
        end else begin
            case (seg)
                7'h7E:   r = {3'b001, 4'd0};
                7'h30:   r = {3'b001, 4'd1};
                7'h6D:   r = {3'b001, 4'd2};
                7'h79:   r = {3'b001, 4'd3};
                7'h33:   r = {3'b001, 4'd4};
                7'h5B:   r = {3'b001, 4'd5};
                7'h5F:   r = {3'b001, 4'd6};
                7'h70:   r = {3'b001, 4'd7};
                7'h7F:   r = {3'b001, 4'd8};
                7'h7B:   r = {3'b001, 4'd9};
                7'h01:   r = 7'b010_0000;
                7'h00:   r = 7'b100_0000;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    always_comb begin
        sclk_s       = sclk_sync_q[SYNC_STAGES-1];
        mosi_s       = mosi_sync_q[SYNC_STAGES-1];
        sel_s        = sel_sync_q[SYNC_STAGES-1];
        sel_fall     = ~sel_s & sel_prev_q;
        sel_rise     = sel_s & ~sel_prev_q;
        sclk_rise    = sclk_s & ~sclk_prev_q;
        frame_addr   = shift_q[11:8];
        frame_data   = shift_q[7:0];
        digit_wr_idx = frame_addr[2:0] - 3'd1;
        frame_ok     = sel_rise_q && (bit_cnt_q == 5'd16);
        decode_trig  = frame_ok && (frame_addr != 4'h0) && (frame_addr <= 4'h9);
        cur_idx      = (state_q == ST_SIGN) ? 3'd6 : idx_q;
        cur_dec      = decode_digit(digit_q[cur_idx], decode_mode_q[cur_idx]);
        acc_d        = acc_q * 20'd10 + {16'd0, cur_dec[3:0]};
        result_d     = cur_dec[5] ? (24'd0 - {4'd0, acc_q}) : {4'd0, acc_q};
    end

    // Synchronisers reset low so a frame in flight at reset release never sees a sel fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q    <= '0;
            mosi_sync_q    <= '0;
            sel_sync_q     <= '0;
            sclk_prev_q    <= 1'b0;
            sel_prev_q     <= 1'b0;
            frame_active_q <= 1'b0;
            sel_rise_q     <= 1'b0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sel_sync_q  <= {sel_sync_q[SYNC_STAGES-2:0], sel};
            sclk_prev_q <= sclk_s;
            sel_prev_q  <= sel_s;
            sel_rise_q  <= 1'b0;
            if (sel_fall) begin
                frame_active_q <= 1'b1;
                bit_cnt_q      <= '0;
                shift_q        <= '0;
            end else if (sel_rise && frame_active_q) begin
                frame_active_q <= 1'b0;
                sel_rise_q     <= 1'b1;
            end else if (frame_active_q && !sel_s && sclk_rise) begin
                shift_q <= {shift_q[10:0], mosi_s};
                if (bit_cnt_q != 5'd17) bit_cnt_q <= bit_cnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) digit_q[k] <= '0;
            decode_mode_q  <= '0;
            intensity_q    <= '0;
            scan_limit_q   <= '0;
            shutdown_q     <= 1'b1;
            display_test_q <= 1'b0;
            frame_strobe_q <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            frame_strobe_q <= 1'b0;
            frame_error_q  <= 1'b0;
            if (frame_ok) begin
                frame_strobe_q <= 1'b1;
                case (frame_addr)
                    4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7, 4'h8: digit_q[digit_wr_idx] <= frame_data[6:0];
                    4'h9:    decode_mode_q  <= frame_data;
                    4'hA:    intensity_q    <= frame_data[3:0];
                    4'hB:    scan_limit_q   <= frame_data[2:0];
                    4'hC:    shutdown_q     <= ~frame_data[0];
                    4'hF:    display_test_q <= frame_data[0];
                    default: ;
                endcase
            end else if (sel_rise_q) begin
                frame_error_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            acc_q          <= '0;
            digits_ok_q    <= 1'b0;
            result_q       <= '0;
            result_ok_q    <= 1'b0;
            pending_q      <= 1'b0;
            value_q        <= '0;
            valid_q        <= 1'b0;
            value_strobe_q <= 1'b0;
        end else begin
            value_strobe_q <= 1'b0;
            pending_q      <= 1'b0;
            if (pending_q) begin
                value_strobe_q <= 1'b1;
                valid_q        <= result_ok_q;
                if (result_ok_q) value_q <= result_q;
            end
            if (decode_trig) begin
                state_q <= ST_LOAD;
            end else begin
                case (state_q)
                    ST_LOAD: begin
                        acc_q       <= '0;
                        digits_ok_q <= 1'b1;
                        idx_q       <= 3'd5;
                        state_q     <= ST_MAC;
                    end
                    ST_MAC: begin
                        acc_q       <= acc_d;
                        digits_ok_q <= digits_ok_q & cur_dec[4];
                        if (idx_q == 3'd0) state_q <= ST_SIGN;
                        else               idx_q   <= idx_q - 3'd1;
                    end
                    ST_SIGN: begin
                        result_q    <= result_d;
                        result_ok_q <= digits_ok_q & (cur_dec[5] | cur_dec[6]);
                        pending_q   <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign value        = value_q;
    assign valid        = valid_q;
    assign value_strobe = value_strobe_q;
    assign frame_strobe = frame_strobe_q;
    assign frame_error  = frame_error_q;
    assign decode_mode  = decode_mode_q;
    assign intensity    = intensity_q;
    assign scan_limit   = scan_limit_q;
    assign shutdown     = shutdown_q;
    assign display_test = display_test_q;

endmodule

// File: tb/tb_max7219_rx.sv
// Bench for max7219_rx: directed frames from the test plan plus randomized register
// traffic checked against a number-level model of the display.
module tb_max7219_rx;
    localparam int SS = 2;

    logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, mosi = 1'b0, sel = 1'b1;
    logic [23:0] value;
    logic valid, value_strobe, frame_strobe, frame_error;
    logic [7:0] decode_mode;
    logic [3:0] intensity;
    logic [2:0] scan_limit;
    logic shutdown, display_test;

    max7219_rx #(.SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .sel(sel),
        .value(value), .valid(valid), .value_strobe(value_strobe),
        .frame_strobe(frame_strobe), .frame_error(frame_error),
        .decode_mode(decode_mode), .intensity(intensity), .scan_limit(scan_limit),
        .shutdown(shutdown), .display_test(display_test)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0, sel_cyc = 0, fs_cyc = 0, vs_cyc = 0;
    int fs_cnt = 0, fe_cnt = 0, vs_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (frame_strobe) begin fs_cnt++; fs_cyc = cyc; end
        if (frame_error) fe_cnt++;
        if (value_strobe) begin vs_cnt++; vs_cyc = cyc; end
    end

    // Reference model: what the display shows, as a plain integer
    logic [7:0] m_dig [8];
    logic [7:0] m_dm;
    logic [3:0] m_int;
    logic [2:0] m_sl;
    logic       m_sd, m_dt, m_valid;
    int         m_value;
    int         raw_pat [10] = '{'h7E, 'h30, 'h6D, 'h79, 'h33, 'h5B, 'h5F, 'h70, 'h7F, 'h7B};

    // 0..9 digit, 10 minus, 11 blank, -1 unrecognised
    function automatic int classify(input logic [7:0] d, input logic code_b);
        if (code_b) begin
            if (d[3:0] <= 4'd9) return int'(d[3:0]);
            if (d[3:0] == 4'hA) return 10;
            if (d[3:0] == 4'hF) return 11;
            return -1;
        end
        for (int i = 0; i < 10; i++) if (int'(d[6:0]) == raw_pat[i]) return i;
        if (d[6:0] == 7'h01) return 10;
        if (d[6:0] == 7'h00) return 11;
        return -1;
    endfunction

    function automatic void model_decode();
        int mag, pw, c;
        bit ok, neg;
        mag = 0; pw = 1; ok = 1;
        for (int k = 0; k < 6; k++) begin
            c = classify(m_dig[k], m_dm[k]);
            if (c < 0 || c > 9) ok = 0;
            else mag += c * pw;
            pw *= 10;
        end
        c = classify(m_dig[6], m_dm[6]);
        neg = (c == 10);
        if (c != 10 && c != 11) ok = 0;
        m_valid = ok;
        if (ok) m_value = neg ? -mag : mag;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 8; k++) m_dig[k] = 8'h00;
        m_dm = 0; m_int = 0; m_sl = 0; m_sd = 1; m_dt = 0; m_valid = 0; m_value = 0;
    endfunction

    function automatic void model_write(input logic [15:0] f);
        int a;
        a = int'(f[11:8]);
        if (a >= 1 && a <= 8) m_dig[a-1] = f[7:0];
        else if (a == 9)  m_dm  = f[7:0];
        else if (a == 10) m_int = f[3:0];
        else if (a == 11) m_sl  = f[2:0];
        else if (a == 12) m_sd  = ~f[0];
        else if (a == 15) m_dt  = f[0];
        if (a >= 1 && a <= 9) model_decode();
    endfunction

    task automatic send_bits(input logic [31:0] d, input int n);
        @(negedge clk); sel = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = d[i];
            repeat (4) @(negedge clk); sclk = 1'b1;
            repeat (4) @(negedge clk); sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        sel = 1'b1; sel_cyc = cyc;
        repeat (20) @(negedge clk);
    endtask

    task automatic send_frame(input logic [15:0] f);
        send_bits({16'd0, f}, 16);
        model_write(f);
    endtask

    task automatic check_regs(input string tag);
        total++; if (decode_mode !== m_dm) begin bad++; $display("FAIL %s decode_mode: got %h want %h", tag, decode_mode, m_dm); end
        total++; if (intensity !== m_int) begin bad++; $display("FAIL %s intensity: got %h want %h", tag, intensity, m_int); end
        total++; if (scan_limit !== m_sl) begin bad++; $display("FAIL %s scan_limit: got %h want %h", tag, scan_limit, m_sl); end
        total++; if (shutdown !== m_sd) begin bad++; $display("FAIL %s shutdown: got %b want %b", tag, shutdown, m_sd); end
        total++; if (display_test !== m_dt) begin bad++; $display("FAIL %s display_test: got %b want %b", tag, display_test, m_dt); end
        total++; if (valid !== m_valid) begin bad++; $display("FAIL %s valid: got %b want %b", tag, valid, m_valid); end
        total++; if (value !== 24'(m_value)) begin bad++; $display("FAIL %s value: got %h want %h", tag, value, 24'(m_value)); end
    endtask

    task automatic test_reset();
        int f0, e0, v0;
        model_reset();
        rst = 1'b1; repeat (5) @(negedge clk); rst = 1'b0;
        f0 = fs_cnt; e0 = fe_cnt; v0 = vs_cnt;
        repeat (20) @(negedge clk);
        check_regs("reset");
        total++; if (shutdown !== 1'b1) begin bad++; $display("FAIL reset shutdown_one: got %b want 1", shutdown); end
        total++; if (fs_cnt - f0 + fe_cnt - e0 + vs_cnt - v0 != 0) begin bad++; $display("FAIL reset strobes: got %0d pulses want 0", fs_cnt - f0 + fe_cnt - e0 + vs_cnt - v0); end
    endtask

    task automatic test_control();
        int f0, v0;
        logic [15:0] fr [5] = '{16'h0900, 16'h0A04, 16'h0B07, 16'h0C01, 16'h0F00};
        f0 = fs_cnt; v0 = vs_cnt;
        for (int i = 0; i < 5; i++) begin
            send_frame(fr[i]);
            if (i == 0) begin
                total++; if (fs_cyc - sel_cyc != SS + 2) begin bad++; $display("FAIL ctrl strobe_latency: got %0d want %0d", fs_cyc - sel_cyc, SS + 2); end
            end
        end
        check_regs("ctrl");
        total++; if (intensity !== 4'd4 || scan_limit !== 3'd7 || shutdown !== 1'b0) begin bad++; $display("FAIL ctrl fixed: got int=%0d sl=%0d sd=%b want 4 7 0", intensity, scan_limit, shutdown); end
        total++; if (fs_cnt - f0 != 5) begin bad++; $display("FAIL ctrl frame_strobes: got %0d want 5", fs_cnt - f0); end
        total++; if (vs_cnt - v0 != 1) begin bad++; $display("FAIL ctrl value_strobes: got %0d want 1", vs_cnt - v0); end
    endtask

    task automatic test_raw_digits();
        logic [15:0] fr [8] = '{16'h017B, 16'h0233, 16'h03F9, 16'h046D, 16'h0530, 16'h067E, 16'h0701, 16'h0800};
        int f0;
        f0 = fs_cnt;
        for (int i = 0; i < 8; i++) send_frame(fr[i]);
        check_regs("raw");
        total++; if (value !== 24'hFFCFC3 || valid !== 1'b1) begin bad++; $display("FAIL raw neg_value: got %h/%b want ffcfc3/1", value, valid); end
        total++; if (vs_cyc - fs_cyc != 9) begin bad++; $display("FAIL raw decode_latency: got %0d want 9", vs_cyc - fs_cyc); end
        total++; if (fs_cnt - f0 != 8) begin bad++; $display("FAIL raw frame_strobes: got %0d want 8", fs_cnt - f0); end
    endtask

    task automatic test_codeb();
        logic [15:0] fr [9] = '{16'h09FF, 16'h0105, 16'h0204, 16'h0303, 16'h0402, 16'h0501, 16'h0600, 16'h070F, 16'h080F};
        for (int i = 0; i < 9; i++) send_frame(fr[i]);
        check_regs("codeb");
        total++; if (value !== 24'd12345 || valid !== 1'b1) begin bad++; $display("FAIL codeb value: got %0d/%b want 12345/1", value, valid); end
    endtask

    task automatic test_bad_length();
        int f0, e0;
        f0 = fs_cnt; e0 = fe_cnt;
        send_bits(32'h0A0F, 15);
        total++; if (fe_cnt - e0 != 1) begin bad++; $display("FAIL len15 frame_error: got %0d want 1", fe_cnt - e0); end
        send_bits(32'h0A0F, 17);
        total++; if (fe_cnt - e0 != 2) begin bad++; $display("FAIL len17 frame_error: got %0d want 2", fe_cnt - e0); end
        send_bits(32'h0000, 0);
        total++; if (fe_cnt - e0 != 3) begin bad++; $display("FAIL len0 frame_error: got %0d want 3", fe_cnt - e0); end
        total++; if (fs_cnt - f0 != 0) begin bad++; $display("FAIL badlen frame_strobe: got %0d want 0", fs_cnt - f0); end
        check_regs("badlen");
    endtask

    task automatic test_invalid_digit();
        logic [15:0] fr [7] = '{16'h0130, 16'h026D, 16'h0379, 16'h0433, 16'h055B, 16'h065F, 16'h0700};
        send_frame(16'h0900);
        total++; if (valid !== 1'b0 || value !== 24'd12345) begin bad++; $display("FAIL inv modeswitch: got %0d/%b want 12345/0", value, valid); end
        for (int i = 0; i < 7; i++) send_frame(fr[i]);
        total++; if (value !== 24'd654321 || valid !== 1'b1) begin bad++; $display("FAIL inv base: got %0d/%b want 654321/1", value, valid); end
        send_frame(16'h044F);
        total++; if (value !== 24'd654321 || valid !== 1'b0) begin bad++; $display("FAIL inv bad_digit: got %0d/%b want 654321/0", value, valid); end
        send_frame(16'h0433);
        total++; if (value !== 24'd654321 || valid !== 1'b1) begin bad++; $display("FAIL inv rewrite: got %0d/%b want 654321/1", value, valid); end
        check_regs("inv");
    endtask

    task automatic test_random();
        logic [15:0] f;
        int r, k, v, f0, v0, a;
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            f = 16'($urandom);
            if (r < 6) begin
                k = $urandom_range(0, 7);
                f[11:8] = 4'(k + 1);
                v = $urandom_range(0, 9);
                if (k <= 5) f[6:0] = m_dm[k] ? {3'($urandom), 4'(v)} : 7'(raw_pat[v]);
                else if (k == 6) f[6:0] = m_dm[k] ? {3'($urandom), (v < 5) ? 4'hA : 4'hF} : ((v < 5) ? 7'h01 : 7'h00);
            end else if (r == 6) begin
                f[11:8] = 4'h9;
                if (v < 3) f[7:0] = 8'h00; else if (v < 6) f[7:0] = 8'hFF;
            end else if (r == 7) begin
                f[11:8] = 4'($urandom_range(10, 15));
            end else if (r == 9) begin
                f[11:8] = 4'h0;
            end
            a = int'(f[11:8]);
            f0 = fs_cnt; v0 = vs_cnt;
            send_frame(f);
            check_regs("rand");
            total++; if (fs_cnt - f0 != 1) begin bad++; $display("FAIL rand frame_strobe: frame %h got %0d want 1", f, fs_cnt - f0); end
            total++; if (vs_cnt - v0 != ((a >= 1 && a <= 9) ? 1 : 0)) begin bad++; $display("FAIL rand value_strobe: frame %h got %0d", f, vs_cnt - v0); end
        end
    endtask

    task automatic test_reset_midframe();
        int f0, e0;
        f0 = fs_cnt; e0 = fe_cnt;
        @(negedge clk); sel = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            mosi = 1'b1; repeat (4) @(negedge clk); sclk = 1'b1; repeat (4) @(negedge clk); sclk = 1'b0;
        end
        rst = 1'b1; repeat (3) @(negedge clk); rst = 1'b0;
        model_reset();
        begin
            logic [15:0] d;
            d = 16'h0A0F;
            for (int i = 15; i >= 0; i--) begin
                mosi = d[i]; repeat (4) @(negedge clk); sclk = 1'b1; repeat (4) @(negedge clk); sclk = 1'b0;
            end
        end
        repeat (4) @(negedge clk); sel = 1'b1;
        repeat (20) @(negedge clk);
        total++; if (fs_cnt - f0 != 0) begin bad++; $display("FAIL midrst frame_strobe: got %0d want 0", fs_cnt - f0); end
        check_regs("midrst");
        send_frame(16'h0A09);
        total++; if (intensity !== 4'd9 || fs_cnt - f0 != 1) begin bad++; $display("FAIL midrst resume: got int=%0d strobes=%0d want 9 1", intensity, fs_cnt - f0); end
        total++; if (fe_cnt - e0 != 0) begin bad++; $display("FAIL midrst frame_error: got %0d want 0", fe_cnt - e0); end
    endtask

    initial begin
        test_reset();
        test_control();
        test_raw_digits();
        test_codeb();
        test_bad_length();
        test_invalid_digit();
        test_random();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
